// File: rtl/cur_monitor.sv
// cur_monitor: four-axis motor current monitor with a shared,
// time-multiplexed filter/compare datapath and latched over-current faults.
//
// Ports:
//   clk, reset          ADC-domain clock, async active-high reset
//   sample              one-cycle strobe, cur1..cur4 valid this cycle
//   cur1..cur4          raw unipolar current codes, axes 1..4
//   cur_limit           over-current threshold (distance from OFFSET)
//   fault_clr[3:0]      per-axis fault/counter clear pulse
//   avg1..avg4          filtered current per axis
//   fault[3:0]          latched over-current flags
//   done                one-cycle pulse when a scan completes
//   overrun             sticky: sample arrived during a scan
//
// Build option: define CUR_AVG_EN for a 4-sample moving-average filter;
// otherwise avg is the captured sample itself.

module cur_monitor #(
   parameter int unsigned TRIP_COUNT = 8,
   parameter logic [15:0] OFFSET     = 16'h8000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        sample,
   input  logic [15:0] cur1,
   input  logic [15:0] cur2,
   input  logic [15:0] cur3,
   input  logic [15:0] cur4,
   input  logic [15:0] cur_limit,
   input  logic [3:0]  fault_clr,
   output logic [15:0] avg1,
   output logic [15:0] avg2,
   output logic [15:0] avg3,
   output logic [15:0] avg4,
   output logic [3:0]  fault,
   output logic        done,
   output logic        overrun
);

   typedef enum logic {IDLE, SCAN} state_t;

   localparam logic [3:0] TRIP = 4'(TRIP_COUNT);

   state_t      state, state_nx;
   logic [1:0]  ch, ch_nx;
   logic        capture, proc, ovr_set;
   logic [3:0]  hit;

   logic [15:0] snap  [4];
   logic [15:0] avg_r [4];
   logic [3:0]  cnt   [4];

   logic [15:0] cur_sel, avg_nx, d;
   logic [3:0]  cnt_sel, cnt_nx;
   logic        over, trip;

`ifdef CUR_AVG_EN
   logic [15:0] hist [4][4];
   logic [17:0] sum  [4];
   logic [17:0] sum_nx;
`endif

   // ---------------- control FSM ----------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         ch    <= 2'd0;
      end else begin
         state <= state_nx;
         ch    <= ch_nx;
      end
   end

   always_comb begin
      state_nx = state;
      ch_nx    = ch;
      capture  = 1'b0;
      proc     = 1'b0;
      ovr_set  = 1'b0;
      unique case (state)
         IDLE: begin
            if (sample) begin
               state_nx = SCAN;
               ch_nx    = 2'd0;
               capture  = 1'b1;
            end
         end
         SCAN: begin
            proc    = 1'b1;
            ovr_set = sample;
            ch_nx   = ch + 2'd1;
            if (ch == 2'd3)
               state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // ------------- shared datapath ---------------
   always_comb begin
      cur_sel = snap[ch];
      cnt_sel = cnt[ch];
`ifdef CUR_AVG_EN
      // True result always fits 18 bits, so modular math is exact.
      sum_nx = sum[ch] + {2'b00, cur_sel} - {2'b00, hist[ch][3]};
      avg_nx = sum_nx[17:2];
`else
      avg_nx = cur_sel;
`endif
      d      = (avg_nx >= OFFSET) ? avg_nx - OFFSET : OFFSET - avg_nx;
      over   = d > cur_limit;
      if (!over)
         cnt_nx = 4'd0;
      else if (cnt_sel >= TRIP)
         cnt_nx = TRIP;
      else
         cnt_nx = cnt_sel + 4'd1;
      trip = proc && over && (cnt_nx == TRIP);
      hit  = 4'b0000;
      if (proc)
         hit[ch] = 1'b1;
   end

   // ------------- per-channel state -------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < 4; k++) begin
            snap[k]  <= OFFSET;
            avg_r[k] <= OFFSET;
            cnt[k]   <= 4'd0;
`ifdef CUR_AVG_EN
            sum[k]   <= {OFFSET, 2'b00};
            for (int i = 0; i < 4; i++)
               hist[k][i] <= OFFSET;
`endif
         end
         fault   <= 4'b0000;
         done    <= 1'b0;
         overrun <= 1'b0;
      end else begin
         if (capture) begin
            snap[0] <= cur1;
            snap[1] <= cur2;
            snap[2] <= cur3;
            snap[3] <= cur4;
         end
         for (int k = 0; k < 4; k++) begin
            // A trip on this channel beats a same-cycle clear.
            if (hit[k] && trip) begin
               cnt[k]   <= cnt_nx;
               fault[k] <= 1'b1;
            end else if (fault_clr[k]) begin
               cnt[k]   <= 4'd0;
               fault[k] <= 1'b0;
            end else if (hit[k]) begin
               cnt[k]   <= cnt_nx;
            end
            if (hit[k]) begin
               avg_r[k] <= avg_nx;
`ifdef CUR_AVG_EN
               sum[k]     <= sum_nx;
               hist[k][0] <= cur_sel;
               hist[k][1] <= hist[k][0];
               hist[k][2] <= hist[k][1];
               hist[k][3] <= hist[k][2];
`endif
            end
         end
         done    <= proc && (ch == 2'd3);
         overrun <= overrun | ovr_set;
      end
   end

   assign avg1 = avg_r[0];
   assign avg2 = avg_r[1];
   assign avg3 = avg_r[2];
   assign avg4 = avg_r[3];

endmodule

// File: tb/tb_cur_monitor.sv
// tb_cur_monitor: self-checking bench for cur_monitor.
// Scan-level reference model compared every cycle, plus directed scenarios.

module tb_cur_monitor;

   localparam int          TRIP = 8;
   localparam int unsigned OFF  = 32'h8000;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        sample = 1'b0;
   logic [15:0] cur1 = 16'h8000, cur2 = 16'h8000;
   logic [15:0] cur3 = 16'h8000, cur4 = 16'h8000;
   logic [15:0] cur_limit = 16'h0800;
   logic [3:0]  fault_clr = 4'b0000;
   logic [15:0] avg1, avg2, avg3, avg4;
   logic [3:0]  fault;
   logic        done, overrun;

   cur_monitor #(
      .TRIP_COUNT(TRIP),
      .OFFSET(16'h8000)
   ) dut (
      .clk(clk), .reset(reset), .sample(sample),
      .cur1(cur1), .cur2(cur2), .cur3(cur3), .cur4(cur4),
      .cur_limit(cur_limit), .fault_clr(fault_clr),
      .avg1(avg1), .avg2(avg2), .avg3(avg3), .avg4(avg4),
      .fault(fault), .done(done), .overrun(overrun)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int done_seen = 0;

   int unsigned m_avg [4];
   int unsigned m_cnt [4];
   int unsigned m_snap [4];
   int unsigned q [4][$];
   logic [3:0]  m_fault;
   logic        m_done, m_ovr;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic m_reset();
      for (int j = 0; j < 4; j++) begin
         m_avg[j] = OFF;
         m_cnt[j] = 0;
         m_snap[j] = OFF;
         q[j].delete();
         repeat (4) q[j].push_back(OFF);
      end
      m_fault = 4'b0000;
      m_done = 1'b0;
      m_ovr = 1'b0;
   endtask

   // One clock of the model: channel pk (or -1) processed, clr applied.
   task automatic m_cycle(input int pk, input logic [3:0] clr);
      int unsigned a, s, dd, nc;
      bit ov;
      for (int j = 0; j < 4; j++) begin
         if (j == pk) begin
`ifdef CUR_AVG_EN
            q[j].push_back(m_snap[j]);
            void'(q[j].pop_front());
            s = 0;
            foreach (q[j][i]) s += q[j][i];
            a = s / 4;
`else
            s = 0;
            a = m_snap[j];
`endif
            dd = (a >= OFF) ? a - OFF : OFF - a;
            ov = dd > int'(cur_limit);
            nc = ov ? ((m_cnt[j] + 1 > TRIP) ? TRIP : m_cnt[j] + 1) : 0;
            m_avg[j] = a;
            if (ov && nc == TRIP) begin
               m_cnt[j] = nc;
               m_fault[j] = 1'b1;
            end else if (clr[j]) begin
               m_cnt[j] = 0;
               m_fault[j] = 1'b0;
            end else begin
               m_cnt[j] = nc;
            end
         end else if (clr[j]) begin
            m_cnt[j] = 0;
            m_fault[j] = 1'b0;
         end
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, " avg1"}, {16'h0, avg1}, m_avg[0]);
      chk({tag, " avg2"}, {16'h0, avg2}, m_avg[1]);
      chk({tag, " avg3"}, {16'h0, avg3}, m_avg[2]);
      chk({tag, " avg4"}, {16'h0, avg4}, m_avg[3]);
      chk({tag, " fault"}, {28'h0, fault}, {28'h0, m_fault});
      chk({tag, " done"}, {31'h0, done}, {31'h0, m_done});
      chk({tag, " overrun"}, {31'h0, overrun}, {31'h0, m_ovr});
      if (done === 1'b1) done_seen++;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         sample = 1'b0;
         fault_clr = 4'b0000;
         tick();
         m_done = 1'b0;
         m_cycle(-1, 4'b0000);
         check_all("idle");
      end
   endtask

   task automatic clr_idle(input logic [3:0] v);
      sample = 1'b0;
      fault_clr = v;
      tick();
      m_done = 1'b0;
      m_cycle(-1, v);
      check_all("clr_idle");
      fault_clr = 4'b0000;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      sample = 1'b0;
      fault_clr = 4'b0000;
      #1;
      m_reset();
      check_all("reset");
      tick();
      reset = 1'b0;
      idle(1);
   endtask

   // Full scan: strobe at t=0, channel t-1 processed at t=1..4.
   task automatic do_scan(input logic [15:0] c1, c2, c3, c4,
                          input int clr_cyc, input logic [3:0] clr_val,
                          input int ovr_cyc);
      for (int t = 0; t < 5; t++) begin
         if (t == 0) begin
            sample = 1'b1;
            cur1 = c1; cur2 = c2; cur3 = c3; cur4 = c4;
            m_snap[0] = c1; m_snap[1] = c2;
            m_snap[2] = c3; m_snap[3] = c4;
         end else begin
            sample = (t == ovr_cyc);
            if (sample) begin
               cur1 = 16'($urandom); cur2 = 16'($urandom);
               cur3 = 16'($urandom); cur4 = 16'($urandom);
            end
         end
         fault_clr = (t == clr_cyc) ? clr_val : 4'b0000;
         tick();
         m_cycle((t == 0) ? -1 : t - 1, fault_clr);
         if (t > 0 && sample) m_ovr = 1'b1;
         m_done = (t == 4);
         check_all("scan");
      end
      sample = 1'b0;
      fault_clr = 4'b0000;
   endtask

   initial begin
      int d0;
      logic [15:0] c [4];
      int cc, oc;

      m_reset();
      tick();
      tick();
      check_all("por");
      reset = 1'b0;
      idle(2);

      // Axis 1 held at 0x1000 over a 0x0800 limit, strobes 10 cycles apart.
      cur_limit = 16'h0800;
      d0 = done_seen;
      for (int i = 0; i < 8; i++) begin
         do_scan(16'h9000, 16'h8000, 16'h8000, 16'h8000, -1, 4'h0, -1);
         idle(5);
`ifndef CUR_AVG_EN
         if (i == 6) chk("pre_trip", {28'h0, fault}, 32'h0);
`endif
      end
`ifndef CUR_AVG_EN
      chk("trip_axis1", {28'h0, fault}, 32'h1);
`endif
      chk("done_count8", done_seen - d0, 8);

      // Axis 2 exactly at the limit never trips; a single in-range
      // sample restarts the count.
      do_reset();
      for (int i = 0; i < 20; i++) begin
         do_scan(16'h8000, 16'h8800, 16'h8000, 16'h8000, -1, 4'h0, -1);
         idle(1);
      end
      chk("eq_limit", {31'h0, fault[1]}, 32'h0);
      for (int i = 0; i < 15; i++) begin
         do_scan(16'h8000, (i == 7) ? 16'h8000 : 16'h7000,
                 16'h8000, 16'h8000, -1, 4'h0, -1);
         idle(1);
      end
`ifndef CUR_AVG_EN
      chk("restart", {31'h0, fault[1]}, 32'h0);
`endif

`ifdef CUR_AVG_EN
      do_reset();
      for (int i = 0; i < 5; i++) begin
         do_scan(16'h8000, 16'h8000, 16'h8400, 16'h8000, -1, 4'h0, -1);
         chk("avg3_ramp", {16'h0, avg3},
             (i < 4) ? 32'h8100 + 32'h100 * i : 32'h8400);
      end
`endif

      // Axis 4: clear during its processing cycle loses to the trip.
      do_reset();
      for (int i = 0; i < 10; i++)
         do_scan(16'h8000, 16'h8000, 16'h8000, 16'h9000, -1, 4'h0, -1);
      chk("trip_axis4", {31'h0, fault[3]}, 32'h1);
      do_scan(16'h8000, 16'h8000, 16'h8000, 16'h9000, 4, 4'b1000, -1);
      chk("trip_wins", {31'h0, fault[3]}, 32'h1);
      idle(1);
      clr_idle(4'b1000);
      chk("clr_idle", {31'h0, fault[3]}, 32'h0);
      for (int i = 0; i < 7; i++)
         do_scan(16'h8000, 16'h8000, 16'h8000, 16'h9000, -1, 4'h0, -1);
      chk("retrip_pre", {31'h0, fault[3]}, 32'h0);
      do_scan(16'h8000, 16'h8000, 16'h8000, 16'h9000, -1, 4'h0, -1);
      chk("retrip", {31'h0, fault[3]}, 32'h1);

      // Strobe during a scan: ignored, sets sticky overrun.
      do_reset();
      chk("ovr_reset", {31'h0, overrun}, 32'h0);
      d0 = done_seen;
      do_scan(16'h8123, 16'h7abc, 16'h9000, 16'h6000, -1, 4'h0, 2);
      idle(3);
      chk("ovr_set", {31'h0, overrun}, 32'h1);
      chk("ovr_done1", done_seen - d0, 1);
`ifndef CUR_AVG_EN
      chk("ovr_snap", {16'h0, avg1}, 32'h8123);
`endif
      do_scan(16'h8000, 16'h8000, 16'h8000, 16'h8000, -1, 4'h0, -1);
      chk("ovr_sticky", {31'h0, overrun}, 32'h1);

      // Reset mid-scan aborts it without a done pulse.
      idle(1);
      d0 = done_seen;
      sample = 1'b1;
      cur1 = 16'hA000; cur2 = 16'h6000; cur3 = 16'h9999; cur4 = 16'h1234;
      tick();
      sample = 1'b0;
      tick();
      reset = 1'b1;
      #1;
      m_reset();
      check_all("midrst");
      tick();
      reset = 1'b0;
      idle(6);
      chk("midrst_nodone", done_seen - d0, 0);
      do_scan(16'h8100, 16'h7f00, 16'h8000, 16'h8000, -1, 4'h0, -1);
      chk("midrst_scan", done_seen - d0, 1);

      // Randomized traffic near the limit.
      do_reset();
      for (int i = 0; i < 300; i++) begin
         cur_limit = 16'($urandom_range(32'h0200, 32'h0A00));
         for (int j = 0; j < 4; j++)
            c[j] = 16'(32'h7400 + $urandom_range(0, 32'h1800));
         cc = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4)) : -1;
         oc = ($urandom_range(0, 19) == 0) ? int'($urandom_range(1, 4)) : -1;
         do_scan(c[0], c[1], c[2], c[3], cc, 4'($urandom), oc);
         if ($urandom_range(0, 7) == 0)
            clr_idle(4'($urandom));
         idle(int'($urandom_range(0, 3)));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
